// File: rtl/fft_vga_pkg.sv
// Shared types and constants for the FFT spectrum-bar framebuffer writer.
package fft_vga_pkg;

  typedef enum logic {
    CAPTURE = 1'b0,
    RENDER  = 1'b1
  } state_t;

  typedef logic [15:0] rgb565_t;

  localparam int          MAG_W          = 16;
  localparam int          DEF_NUM_BINS   = 64;
  localparam int          DEF_MAG_SHIFT  = 4;
  localparam int          DEF_BAR_W      = 5;
  localparam int          DEF_H_RES      = 320;
  localparam int          DEF_V_RES      = 240;
  localparam logic [31:0] DEF_FB_BASE    = 32'h0000_0000;
  localparam rgb565_t     COLOR_GREEN    = 16'h07E0;
  localparam rgb565_t     COLOR_BLACK    = 16'h0000;

  // Bits needed to hold a bar height in the range 0..v_res inclusive.
  function automatic int height_w(input int v_res);
    return $clog2(v_res + 1);
  endfunction

endpackage

// File: rtl/fft_bar_renderer_if.sv
// Bin stream sink plus Avalon-MM write master signals of the bar renderer.
interface fft_bar_renderer_if;
  import fft_vga_pkg::*;

  logic             snk_valid;
  logic             snk_ready;
  logic             snk_sop;
  logic             snk_eop;
  logic [MAG_W-1:0] snk_mag;
  logic [31:0]      avm_address;
  logic             avm_write;
  rgb565_t          avm_writedata;
  logic             avm_waitrequest;

  modport master (
    input  snk_valid, snk_sop, snk_eop, snk_mag, avm_waitrequest,
    output snk_ready, avm_address, avm_write, avm_writedata
  );

  modport slave (
    output snk_valid, snk_sop, snk_eop, snk_mag, avm_waitrequest,
    input  snk_ready, avm_address, avm_write, avm_writedata
  );
endinterface

// File: rtl/fb_scan_counter.sv
// Row-major framebuffer scan: x/y position, bar/in-bar bin tracking and the
// running byte address, all stepped by a single advance strobe.
module fb_scan_counter
  import fft_vga_pkg::*;
#(
  parameter int          NUM_BINS = DEF_NUM_BINS,
  parameter int          H_RES    = DEF_H_RES,
  parameter int          V_RES    = DEF_V_RES,
  parameter int          BAR_W    = DEF_BAR_W,
  parameter logic [31:0] FB_BASE  = DEF_FB_BASE,
  localparam int         BIN_W    = $clog2(NUM_BINS),
  localparam int         Y_W      = $clog2(V_RES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic             last,
  output logic [BIN_W-1:0] bin,
  output logic [Y_W-1:0]   y,
  output logic [31:0]      addr
);

  localparam int X_W   = $clog2(H_RES);
  localparam int INB_W = $clog2(BAR_W + 1);

  logic [X_W-1:0]   x_r;
  logic [Y_W-1:0]   y_r;
  logic [BIN_W-1:0] bar_r;
  logic [INB_W-1:0] inbar_r;
  logic [31:0]      addr_r;
  logic             x_end_s;
  logic             y_end_s;
  logic             inbar_end_s;

  assign x_end_s     = (x_r == X_W'(H_RES - 1));
  assign y_end_s     = (y_r == Y_W'(V_RES - 1));
  assign inbar_end_s = (inbar_r == INB_W'(BAR_W - 1));
  assign last        = x_end_s && y_end_s;
  assign bin         = bar_r;
  assign y           = y_r;
  assign addr        = addr_r;

  // Scan position registers; the final pixel wraps everything back to the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r     <= '0;
      y_r     <= '0;
      bar_r   <= '0;
      inbar_r <= '0;
      addr_r  <= FB_BASE;
    end else if (advance) begin
      if (last) begin
        x_r     <= '0;
        y_r     <= '0;
        bar_r   <= '0;
        inbar_r <= '0;
        addr_r  <= FB_BASE;
      end else begin
        addr_r <= addr_r + 32'd2;
        if (x_end_s) begin
          x_r     <= '0;
          bar_r   <= '0;
          inbar_r <= '0;
          y_r     <= y_r + Y_W'(1);
        end else begin
          x_r <= x_r + X_W'(1);
          if (inbar_end_s) begin
            inbar_r <= '0;
            bar_r   <= bar_r + BIN_W'(1);
          end else begin
            inbar_r <= inbar_r + INB_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/fft_bar_renderer.sv
// Captures one packet of FFT bins as bar heights, then writes a full RGB565
// bar-graph frame to the framebuffer through an Avalon-MM write master.
module fft_bar_renderer
  import fft_vga_pkg::*;
#(
  parameter int          NUM_BINS  = DEF_NUM_BINS,
  parameter int          MAG_SHIFT = DEF_MAG_SHIFT,
  parameter int          H_RES     = DEF_H_RES,
  parameter int          V_RES     = DEF_V_RES,
  parameter int          BAR_W     = DEF_BAR_W,
  parameter logic [31:0] FB_BASE   = DEF_FB_BASE,
  parameter rgb565_t     BAR_COLOR = COLOR_GREEN,
  parameter rgb565_t     BG_COLOR  = COLOR_BLACK
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  fft_bar_renderer_if.master  bus,
  output logic                busy,
  output logic                frame_done
);

  localparam int HW    = height_w(V_RES);
  localparam int BIN_W = $clog2(NUM_BINS);
  localparam int Y_W   = $clog2(V_RES);
  localparam int IDX_W = $clog2(NUM_BINS + 1);

  function automatic logic [HW-1:0] mag_to_height(input logic [MAG_W-1:0] mag);
    logic [MAG_W-1:0] scaled;
    scaled = mag >> MAG_SHIFT;
    return (scaled > MAG_W'(V_RES)) ? HW'(V_RES) : HW'(scaled);
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic             in_pkt_r;
  logic [IDX_W-1:0] idx_r;
  logic [HW-1:0]    heights_r [NUM_BINS];
  logic             frame_done_r;
  logic             accept_s;
  logic             rendering_s;
  logic             advance_s;
  logic             last_s;
  logic             lit_s;
  logic [BIN_W-1:0] scan_bin_s;
  logic [Y_W-1:0]   scan_y_s;
  logic [31:0]      scan_addr_s;

  assign rendering_s = (state_r == RENDER);
  assign accept_s    = bus.snk_valid && (state_r == CAPTURE);
  assign advance_s   = rendering_s && !bus.avm_waitrequest;

  fb_scan_counter #(
    .NUM_BINS (NUM_BINS),
    .H_RES    (H_RES),
    .V_RES    (V_RES),
    .BAR_W    (BAR_W),
    .FB_BASE  (FB_BASE)
  ) u_scan (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .advance (advance_s),
    .last    (last_s),
    .bin     (scan_bin_s),
    .y       (scan_y_s),
    .addr    (scan_addr_s)
  );

  // State register and end-of-frame pulse.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r      <= CAPTURE;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      frame_done_r <= advance_s && last_s;
    end
  end

  // Next state: an accepted eop inside a packet starts rendering.
  always_comb begin
    state_s = state_r;
    case (state_r)
      CAPTURE: begin
        if (accept_s && bus.snk_eop && (bus.snk_sop || in_pkt_r)) begin
          state_s = RENDER;
        end else begin
          state_s = CAPTURE;
        end
      end
      RENDER: begin
        if (advance_s && last_s) begin
          state_s = CAPTURE;
        end else begin
          state_s = RENDER;
        end
      end
      default: state_s = CAPTURE;
    endcase
  end

  // Bin capture; sop restarts the packet and clears stale heights.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      in_pkt_r <= 1'b0;
      idx_r    <= '0;
      for (int i = 0; i < NUM_BINS; i++) heights_r[i] <= '0;
    end else if (accept_s && bus.snk_sop) begin
      for (int i = 0; i < NUM_BINS; i++) heights_r[i] <= '0;
      heights_r[0] <= mag_to_height(bus.snk_mag);
      idx_r        <= IDX_W'(1);
      in_pkt_r     <= !bus.snk_eop;
    end else if (accept_s && in_pkt_r) begin
      if (idx_r < IDX_W'(NUM_BINS)) begin
        heights_r[idx_r[BIN_W-1:0]] <= mag_to_height(bus.snk_mag);
        idx_r                       <= idx_r + IDX_W'(1);
      end
      in_pkt_r <= !bus.snk_eop;
    end
  end

  assign lit_s = (int'(scan_y_s) >= (V_RES - int'(heights_r[scan_bin_s])));

  assign bus.snk_ready     = (state_r == CAPTURE);
  assign bus.avm_write     = rendering_s;
  assign bus.avm_address   = rendering_s ? scan_addr_s : 32'h0000_0000;
  assign bus.avm_writedata = rendering_s ? (lit_s ? BAR_COLOR : BG_COLOR) : 16'h0000;
  assign busy              = rendering_s;
  assign frame_done        = frame_done_r;

endmodule

// File: tb/tb_fft_bar_renderer.sv
// Self-checking bench for fft_bar_renderer on a reduced 40x48 geometry.
module tb_fft_bar_renderer;
  import fft_vga_pkg::*;

  localparam int          NB   = 8;
  localparam int          BW   = 5;
  localparam int          H    = NB * BW;
  localparam int          V    = 48;
  localparam int          SH   = 4;
  localparam int          NPIX = H * V;
  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam logic [15:0] BAR  = 16'h07E0;
  localparam logic [15:0] BG   = 16'h0000;

  typedef struct {
    int          bin;
    logic [15:0] mag;
    int          px;
    int          py;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    bit          sop;
    bit          eop;
    logic [15:0] mag;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic frame_done;

  fft_bar_renderer_if bus();

  fft_bar_renderer #(
    .NUM_BINS  (NB),
    .MAG_SHIFT (SH),
    .H_RES     (H),
    .V_RES     (V),
    .BAR_W     (BW),
    .FB_BASE   (BASE),
    .BAR_COLOR (BAR),
    .BG_COLOR  (BG)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          exp_h [NB];
  bit          m_inpkt = 1'b0;
  int          m_idx = 0;
  int          pix_k = 0;
  int          frames = 0;
  logic [15:0] fb [NPIX];
  bit          stall_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [15:0] prev_data;
  beat_t       bq [$];
  vec_t        tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mag2h(input logic [15:0] m);
    int h;
    h = int'(m) / (1 << SH);
    return (h > V) ? V : h;
  endfunction

  function automatic logic [31:0] exp_addr(input int k);
    return BASE + 32'(2 * k);
  endfunction

  function automatic logic [15:0] exp_pix(input int k);
    int x, y;
    x = k % H;
    y = k / H;
    return (y >= V - exp_h[x / BW]) ? BAR : BG;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) exp_h[i] = 0;
    m_inpkt = 1'b0;
    m_idx   = 0;
  endtask

  // Pixel monitor: checks every accepted write against the reference frame.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pix_k      = 0;
        prev_stall = 1'b0;
      end else begin
        if (bus.avm_write) begin
          if (prev_stall) begin
            check("stall_addr", bus.avm_address, prev_addr);
            check("stall_data", 32'(bus.avm_writedata), 32'(prev_data));
          end
          if (!bus.avm_waitrequest) begin
            check("pix_addr", bus.avm_address, exp_addr(pix_k));
            check("pix_data", 32'(bus.avm_writedata), 32'(exp_pix(pix_k)));
            if (pix_k < NPIX) fb[pix_k] = bus.avm_writedata;
            pix_k++;
          end
        end
        prev_stall = bus.avm_write && bus.avm_waitrequest;
        prev_addr  = bus.avm_address;
        prev_data  = bus.avm_writedata;
        if (frame_done) begin
          check("done_pix_count", 32'(pix_k), 32'(NPIX));
          frames++;
          pix_k = 0;
        end
      end
    end
  end

  // Slave stall generator: random waitrequest runs of at most 3 cycles.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    bus.avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_en && stall_cnt < 3 && $urandom_range(0, 1) == 1) begin
        bus.avm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        bus.avm_waitrequest = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  task automatic beat(input bit sop, input bit eop, input logic [15:0] mag);
    bus.snk_valid = 1'b1;
    bus.snk_sop   = sop;
    bus.snk_eop   = eop;
    bus.snk_mag   = mag;
    @(posedge clk);
    #1;
    bus.snk_valid = 1'b0;
    bus.snk_sop   = 1'b0;
    bus.snk_eop   = 1'b0;
  endtask

  // Applies bq to the model (packet rules) and to the DUT.
  task automatic send(input bit expect_render);
    for (int i = 0; i < bq.size(); i++) begin
      if (bq[i].sop) begin
        for (int b = 0; b < NB; b++) exp_h[b] = 0;
        exp_h[0] = mag2h(bq[i].mag);
        m_idx    = 1;
        m_inpkt  = !bq[i].eop;
      end else if (m_inpkt) begin
        if (m_idx < NB) begin
          exp_h[m_idx] = mag2h(bq[i].mag);
          m_idx++;
        end
        m_inpkt = !bq[i].eop;
      end
      beat(bq[i].sop, bq[i].eop, bq[i].mag);
    end
    if (expect_render) begin
      @(negedge clk);
      check("write_first", 32'(bus.avm_write), 32'd1);
      check("busy_render", 32'(busy), 32'd1);
    end
  endtask

  task automatic wait_frame();
    int f0;
    bit seen;
    f0 = frames;
    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (frames != f0) seen = 1'b1;
    end
    check("frame_seen", 32'(frames - f0), 32'd1);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(bus.snk_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic push_full(input bit rnd, input logic [15:0] val);
    bq.delete();
    for (int i = 0; i < NB; i++)
      bq.push_back('{sop: (i == 0), eop: (i == NB - 1), mag: rnd ? 16'($urandom_range(0, 65535)) : val});
  endtask

  initial begin
    int n;
    bit reached;
    tbl[0]  = '{bin: 0, mag: 16'd320,   px: 0,  py: 27, exp: BG};
    tbl[1]  = '{bin: 0, mag: 16'd320,   px: 0,  py: 28, exp: BAR};
    tbl[2]  = '{bin: 0, mag: 16'd320,   px: 4,  py: 47, exp: BAR};
    tbl[3]  = '{bin: 0, mag: 16'd320,   px: 5,  py: 47, exp: BG};
    tbl[4]  = '{bin: 7, mag: 16'hFFFF,  px: 35, py: 0,  exp: BAR};
    tbl[5]  = '{bin: 7, mag: 16'hFFFF,  px: 39, py: 0,  exp: BAR};
    tbl[6]  = '{bin: 7, mag: 16'hFFFF,  px: 34, py: 0,  exp: BG};
    tbl[7]  = '{bin: 3, mag: 16'd15,    px: 15, py: 47, exp: BG};
    tbl[8]  = '{bin: 3, mag: 16'd16,    px: 15, py: 47, exp: BAR};
    tbl[9]  = '{bin: 3, mag: 16'd16,    px: 19, py: 46, exp: BG};
    tbl[10] = '{bin: 5, mag: 16'd767,   px: 25, py: 0,  exp: BG};
    tbl[11] = '{bin: 5, mag: 16'd768,   px: 25, py: 0,  exp: BAR};

    bus.snk_valid = 1'b0;
    bus.snk_sop   = 1'b0;
    bus.snk_eop   = 1'b0;
    bus.snk_mag   = 16'h0000;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.snk_ready), 32'd1);
    check("rst_write", 32'(bus.avm_write), 32'd0);
    check("rst_addr", bus.avm_address, 32'd0);
    check("rst_data", 32'(bus.avm_writedata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    push_full(1'b0, 16'h0000);
    send(1'b1);
    wait_frame();

    for (int t = 0; t < 12; t++) begin
      bq.delete();
      for (int i = 0; i < NB; i++)
        bq.push_back('{sop: (i == 0), eop: (i == NB - 1), mag: (i == tbl[t].bin) ? tbl[t].mag : 16'h0000});
      send(1'b1);
      wait_frame();
      check($sformatf("tbl_pix%0d", t), 32'(fb[tbl[t].py * H + tbl[t].px]), 32'(tbl[t].exp));
    end

    stall_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, NB + 2);
      bq.delete();
      for (int i = 0; i < n; i++)
        bq.push_back('{sop: (i == 0), eop: (i == n - 1), mag: 16'($urandom_range(0, 65535))});
      send(1'b1);
      wait_frame();
    end
    stall_en = 1'b0;

    bq.delete();
    bq.push_back('{sop: 1'b0, eop: 1'b1, mag: 16'hFFFF});
    send(1'b0);
    repeat (5) @(negedge clk);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_write", 32'(bus.avm_write), 32'd0);
    @(posedge clk);
    #1;

    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back('{sop: (i == 0), eop: (i == 3), mag: 16'hFFFF});
    send(1'b1);
    bus.snk_valid = 1'b1;
    bus.snk_sop   = 1'b1;
    bus.snk_eop   = 1'b1;
    bus.snk_mag   = 16'h0000;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("ready_in_render", 32'(bus.snk_ready), 32'd0);
    end
    bus.snk_valid = 1'b0;
    bus.snk_sop   = 1'b0;
    bus.snk_eop   = 1'b0;
    wait_frame();
    check("short_bin3", 32'(fb[(V - 1) * H + 3 * BW]), 32'(BAR));
    check("short_bin4", 32'(fb[(V - 1) * H + 4 * BW]), 32'(BG));

    bq.delete();
    bq.push_back('{sop: 1'b1, eop: 1'b0, mag: 16'h0100});
    bq.push_back('{sop: 1'b0, eop: 1'b0, mag: 16'hFFFF});
    bq.push_back('{sop: 1'b1, eop: 1'b0, mag: 16'h0200});
    bq.push_back('{sop: 1'b0, eop: 1'b1, mag: 16'h0300});
    send(1'b1);
    wait_frame();
    check("restart_bin0", 32'(fb[(V - 32) * H]), 32'(BAR));
    check("restart_bin0_top", 32'(fb[(V - 33) * H]), 32'(BG));
    check("restart_bin1", 32'(fb[BW]), 32'(BAR));
    check("restart_bin2", 32'(fb[(V - 1) * H + 2 * BW]), 32'(BG));

    push_full(1'b1, 16'h0000);
    send(1'b1);
    reached = 1'b0;
    for (int c = 0; c < 5000 && !reached; c++) begin
      @(negedge clk);
      if (pix_k >= 1000) reached = 1'b1;
    end
    check("reach_pix1000", 32'(reached), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_write", 32'(bus.avm_write), 32'd0);
    check("midrst_addr", bus.avm_address, 32'd0);
    check("midrst_data", 32'(bus.avm_writedata), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(frame_done), 32'd0);
    check("midrst_ready", 32'(bus.snk_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_full(1'b1, 16'h0000);
    send(1'b1);
    wait_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
